// File: rtl/bug_route_sched.sv
// ---------------------------------------------------------------------------
// bug_route_sched
// Waypoint scheduler for the on-screen bug sprite. It walks the sprite through
// a programmable table of waypoints, one pixel per prescaler tick, along
// Manhattan paths (X axis first, then Y). The table is loaded through a small
// config port while the scheduler is not busy.
//
// Ports
//   pclk      in   pixel clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin the route (sampled only while idle)
//   pause     in   freeze prescaler and position while high
//   abort     in   return to idle, holding position
//   loop_en   in   wrap to waypoint 0 after the last waypoint
//   cfg_len   in   number of active waypoints (0 = empty, clamped to N_WP)
//   cfg_we    in   table write strobe (ignored while busy)
//   cfg_addr  in   table write index
//   cfg_x/y   in   waypoint coordinates
//   xpos/ypos out  sprite position
//   rotation  out  0 up, 1 left, 2 down, 3 right
//   busy      out  high while loading/moving/arriving
//   wp_idx    out  current target waypoint index
//   lap       out  one-cycle pulse on wrap to waypoint 0
//   done      out  one-cycle pulse when a non-looping route finishes
// ---------------------------------------------------------------------------
module bug_route_sched #(
  parameter int N_WP     = 8,
  parameter int STEP_DIV = 40000,
  parameter int HOME_X   = 50,
  parameter int HOME_Y   = 50
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        abort,
  input  logic        loop_en,
  input  logic [3:0]  cfg_len,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_x,
  input  logic [11:0] cfg_y,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  rotation,
  output logic        busy,
  output logic [2:0]  wp_idx,
  output logic        lap,
  output logic        done
);

  localparam int PS_W = $clog2(STEP_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_ARRIVE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [11:0]     xpos_r, xpos_nxt_s;
  logic [11:0]     ypos_r, ypos_nxt_s;
  logic [1:0]      rot_r, rot_nxt_s;
  logic [2:0]      wp_idx_r, wp_idx_nxt_s;
  logic [11:0]     tgt_x_r, tgt_x_nxt_s;
  logic [11:0]     tgt_y_r, tgt_y_nxt_s;
  logic [PS_W-1:0] ps_r, ps_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            lap_r, lap_nxt_s;
  logic            done_r, done_nxt_s;

  logic [11:0]     tbl_x_r [N_WP];
  logic [11:0]     tbl_y_r [N_WP];

  logic [3:0]      eff_len_s;
  logic            tbl_we_s;

  // Lengths above the table depth behave as a full table.
  assign eff_len_s = (cfg_len > 4'(N_WP)) ? 4'(N_WP) : cfg_len;

  // The table may only change while no route is in flight, so the bug never
  // chases a waypoint that moved underneath it.
  assign tbl_we_s = cfg_we && (32'(cfg_addr) < N_WP) &&
                    ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // Next-state, datapath and pulse outputs; abort outranks pause, which
  // outranks the prescaler tick.
  always_comb begin
    state_nxt_s  = state_r;
    xpos_nxt_s   = xpos_r;
    ypos_nxt_s   = ypos_r;
    rot_nxt_s    = rot_r;
    wp_idx_nxt_s = wp_idx_r;
    tgt_x_nxt_s  = tgt_x_r;
    tgt_y_nxt_s  = tgt_y_r;
    ps_nxt_s     = ps_r;
    lap_nxt_s    = 1'b0;
    done_nxt_s   = 1'b0;

    if ((state_r != ST_IDLE) && abort) begin
      state_nxt_s = ST_IDLE;
      ps_nxt_s    = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (eff_len_s != 4'd0)) begin
            state_nxt_s  = ST_LOAD;
            wp_idx_nxt_s = 3'd0;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end
        ST_LOAD: begin
          tgt_x_nxt_s = tbl_x_r[wp_idx_r];
          tgt_y_nxt_s = tbl_y_r[wp_idx_r];
          ps_nxt_s    = '0;
          state_nxt_s = ST_MOVE;
        end
        ST_MOVE: begin
          if (pause) begin
            state_nxt_s = ST_MOVE;
          end else if ((xpos_r == tgt_x_r) && (ypos_r == tgt_y_r)) begin
            state_nxt_s = ST_ARRIVE;
          end else if (ps_r == PS_LAST) begin
            ps_nxt_s = '0;
            // X is closed out completely before Y moves at all.
            if (xpos_r != tgt_x_r) begin
              if (tgt_x_r > xpos_r) begin
                xpos_nxt_s = xpos_r + 12'd1;
                rot_nxt_s  = 2'd3;
              end else begin
                xpos_nxt_s = xpos_r - 12'd1;
                rot_nxt_s  = 2'd1;
              end
            end else begin
              if (tgt_y_r > ypos_r) begin
                ypos_nxt_s = ypos_r + 12'd1;
                rot_nxt_s  = 2'd2;
              end else begin
                ypos_nxt_s = ypos_r - 12'd1;
                rot_nxt_s  = 2'd0;
              end
            end
          end else begin
            ps_nxt_s = ps_r + PS_W'(1);
          end
        end
        ST_ARRIVE: begin
          // Length is re-read here, so a shrunken (or zeroed) route simply
          // ends at the next arrival instead of indexing past its end.
          if (({1'b0, wp_idx_r} + 4'd1) < eff_len_s) begin
            wp_idx_nxt_s = wp_idx_r + 3'd1;
            state_nxt_s  = ST_LOAD;
          end else if (loop_en) begin
            wp_idx_nxt_s = 3'd0;
            lap_nxt_s    = 1'b1;
            state_nxt_s  = ST_LOAD;
          end else begin
            state_nxt_s  = ST_DONE;
          end
        end
        ST_DONE: begin
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          ps_nxt_s    = '0;
        end
      endcase
    end

    busy_nxt_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_MOVE) ||
                 (state_nxt_s == ST_ARRIVE);
  end

  // State, position and registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      xpos_r   <= 12'(HOME_X);
      ypos_r   <= 12'(HOME_Y);
      rot_r    <= 2'd0;
      wp_idx_r <= 3'd0;
      tgt_x_r  <= 12'd0;
      tgt_y_r  <= 12'd0;
      ps_r     <= '0;
      busy_r   <= 1'b0;
      lap_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      xpos_r   <= xpos_nxt_s;
      ypos_r   <= ypos_nxt_s;
      rot_r    <= rot_nxt_s;
      wp_idx_r <= wp_idx_nxt_s;
      tgt_x_r  <= tgt_x_nxt_s;
      tgt_y_r  <= tgt_y_nxt_s;
      ps_r     <= ps_nxt_s;
      busy_r   <= busy_nxt_s;
      lap_r    <= lap_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  // Waypoint table storage.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WP; i++) begin
        tbl_x_r[i] <= 12'd0;
        tbl_y_r[i] <= 12'd0;
      end
    end else if (tbl_we_s) begin
      tbl_x_r[cfg_addr] <= cfg_x;
      tbl_y_r[cfg_addr] <= cfg_y;
    end
  end

  assign xpos     = xpos_r;
  assign ypos     = ypos_r;
  assign rotation = rot_r;
  assign busy     = busy_r;
  assign wp_idx   = wp_idx_r;
  assign lap      = lap_r;
  assign done     = done_r;

endmodule

// File: tb/tb_bug_route_sched.sv
// ---------------------------------------------------------------------------
// tb_bug_route_sched
// Directed bench for bug_route_sched with STEP_DIV=4. A behavioural route
// model advances once per clock and every cycle's outputs are compared
// against it; hand-computed latencies and end positions pin the model.
// ---------------------------------------------------------------------------
module tb_bug_route_sched;

  localparam int SD = 4;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        start, pause, abort, loop_en;
  logic [3:0]  cfg_len;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_x, cfg_y;
  logic [11:0] xpos, ypos;
  logic [1:0]  rotation;
  logic        busy;
  logic [2:0]  wp_idx;
  logic        lap, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: phase 0 idle, 1 fetching target, 2 walking, 3 arrived, 4 finishing.
  int phase, mx, my, mrot, midx, mtx, mty, mcnt;
  bit mbusy, mlap, mdone;
  int tx[8];
  int ty[8];

  bug_route_sched #(.N_WP(8), .STEP_DIV(SD), .HOME_X(50), .HOME_Y(50)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .loop_en(loop_en), .cfg_len(cfg_len), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .xpos(xpos), .ypos(ypos), .rotation(rotation),
    .busy(busy), .wp_idx(wp_idx), .lap(lap), .done(done)
  );

  always #5 pclk = ~pclk;

  task automatic model_reset();
    phase = 0; mx = 50; my = 50; mrot = 0; midx = 0; mtx = 0; mty = 0; mcnt = 0;
    mbusy = 0; mlap = 0; mdone = 0;
    for (int i = 0; i < 8; i++) begin tx[i] = 0; ty[i] = 0; end
  endtask

  // Advance the model by one clock using the inputs that the next edge samples.
  task automatic model_advance();
    int nph, len;
    bit nlap, ndone;
    nph = phase; nlap = 0; ndone = 0;
    len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
    if (phase != 0 && abort) begin
      nph = 0; mcnt = 0;
    end else begin
      case (phase)
        0: if (start && len != 0) begin nph = 1; midx = 0; end
        1: begin mtx = tx[midx]; mty = ty[midx]; mcnt = 0; nph = 2; end
        2: if (!pause) begin
             if (mx == mtx && my == mty) nph = 3;
             else if (mcnt == SD - 1) begin
               mcnt = 0;
               if (mx != mtx) begin
                 mrot = (mtx > mx) ? 3 : 1;
                 mx   = mx + ((mtx > mx) ? 1 : -1);
               end else begin
                 mrot = (mty > my) ? 2 : 0;
                 my   = my + ((mty > my) ? 1 : -1);
               end
             end else mcnt++;
           end
        3: if (midx + 1 < len) begin midx++; nph = 1; end
           else if (loop_en) begin midx = 0; nlap = 1; nph = 1; end
           else nph = 4;
        4: begin ndone = 1; nph = 0; end
        default: nph = 0;
      endcase
    end
    if ((phase == 0 || phase == 4) && cfg_we && int'(cfg_addr) < 8) begin
      tx[cfg_addr] = int'(cfg_x);
      ty[cfg_addr] = int'(cfg_y);
    end
    phase = nph; mlap = nlap; mdone = ndone;
    mbusy = (nph >= 1 && nph <= 3);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then return
  // 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step();
    logic [31:0] act, exp;
    @(negedge pclk);
    cyc++;
    if (!rst_n) model_reset();
    act = {xpos, ypos, rotation, busy, wp_idx, lap, done};
    exp = {12'(mx), 12'(my), 2'(mrot), mbusy, 3'(midx), mlap, mdone};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act, exp);
    end
    if (rst_n) model_advance();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input int a, input int x, input int y);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_x = 12'(x); cfg_y = 12'(y);
    step();
    cfg_we = 1'b0;
  endtask

  // Pulse start, then count edges until done is seen (bounded).
  task automatic run(input int budget, output int n);
    start = 1'b1; step(); start = 1'b0; n = 1;
    while (done !== 1'b1 && n < budget) begin step(); n++; end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 0; pause = 0; abort = 0; loop_en = 0;
    cfg_len = 4'd0; cfg_we = 0; cfg_addr = 3'd0; cfg_x = 12'd0; cfg_y = 12'd0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_xpos", int'(xpos), 50);
    chk("reset_busy", int'(busy), 0);

    // 1: async reset in the middle of a move
    wr(0, 60, 50);
    cfg_len = 4'd1;
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    chk("t1_moved", int'(xpos), 51);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_x", int'(xpos), 50);
    chk("t1_rst_y", int'(ypos), 50);
    chk("t1_rst_rot", int'(rotation), 0);
    chk("t1_rst_busy", int'(busy), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 2: two-waypoint single-shot route
    wr(0, 53, 50);
    wr(1, 53, 48);
    cfg_len = 4'd2; loop_en = 1'b0;
    run(200, n);
    chk("t2_done_cycles", n, 28);
    chk("t2_final_x", int'(xpos), 53);
    chk("t2_final_y", int'(ypos), 48);
    chk("t2_rot", int'(rotation), 0);
    step();
    chk("t2_done_pulse", int'(done), 0);

    // 4: pause for 10 cycles in the middle of a segment
    wr(0, 56, 48);
    cfg_len = 4'd1;
    start = 1'b1; step(); start = 1'b0; n = 1;
    repeat (3) begin step(); n++; end
    pause = 1'b1;
    repeat (10) begin step(); n++; end
    chk("t4_frozen_x", int'(xpos), 53);
    pause = 1'b0;
    while (done !== 1'b1 && n < 200) begin step(); n++; end
    chk("t4_done_cycles", n, 27);
    chk("t4_final_x", int'(xpos), 56);
    chk("t4_rot_right", int'(rotation), 3);

    // 3: looping route, returns X first then Y, lap on wrap
    wr(0, 53, 50);
    cfg_len = 4'd2; loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0; n = 1;
    while (lap !== 1'b1 && n < 200) begin step(); n++; end
    chk("t3_lap_cycles", n, 35);
    chk("t3_lap_idx", int'(wp_idx), 0);
    repeat (3) step();

    // 5: abort during move, then abort together with pause
    abort = 1'b1; step(); abort = 1'b0;
    chk("t5_abort_busy", int'(busy), 0);
    chk("t5_abort_done", int'(done), 0);
    loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (2) step();
    abort = 1'b1; pause = 1'b1; step(); abort = 1'b0; pause = 1'b0;
    chk("t5_abort_pause_busy", int'(busy), 0);
    step();
    run(200, n);
    chk("t5_restart_cycles", n, 24);
    chk("t5_restart_y", int'(ypos), 48);

    // 6: empty route, write while busy, over-length clamp
    cfg_len = 4'd0;
    start = 1'b1; repeat (3) step(); start = 1'b0;
    chk("t6_empty_busy", int'(busy), 0);
    cfg_len = 4'd2;
    start = 1'b1; step(); start = 1'b0; n = 1;
    repeat (4) begin step(); n++; end
    wr(1, 100, 100); n++;
    while (done !== 1'b1 && n < 200) begin step(); n++; end
    chk("t6_busy_write_x", int'(xpos), 53);
    chk("t6_busy_write_y", int'(ypos), 48);
    wr(0, 54, 48); wr(1, 54, 49); wr(2, 55, 49); wr(3, 55, 50);
    wr(4, 54, 50); wr(5, 54, 49); wr(6, 53, 49); wr(7, 53, 48);
    cfg_len = 4'd15;
    run(300, n);
    chk("t6_clamp_cycles", n, 58);
    chk("t6_clamp_x", int'(xpos), 53);
    chk("t6_clamp_y", int'(ypos), 48);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
